// File: rtl/mini_div.sv
// Sequential unsigned restoring divider: one quotient bit per clock, with
// divide-by-zero short-circuit straight to DONE.
module mini_div #(
  parameter int unsigned DIVIDEND_W = 8,
  parameter int unsigned DIVISOR_W  = 4
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iStart,
  input  logic [DIVIDEND_W-1:0] iDividend,
  input  logic [DIVISOR_W-1:0]  iDivisor,
  output logic                  oBusy,
  output logic                  oDone,
  output logic [DIVIDEND_W-1:0] oQuotient,
  output logic [DIVISOR_W-1:0]  oRemainder,
  output logic                  oDivByZero
);

  localparam int unsigned CNT_W  = $clog2(DIVIDEND_W + 1);
  localparam int unsigned PART_W = DIVISOR_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [DIVIDEND_W-1:0] dvd_q, dvd_d;
  logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
  logic [DIVISOR_W-1:0]  rem_q, rem_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [DIVIDEND_W-1:0] quo_q, quo_d;
  logic [DIVISOR_W-1:0]  rem_out_q, rem_out_d;
  logic                  dbz_q, dbz_d;

  logic [PART_W-1:0]     partial;
  logic [PART_W-1:0]     diff;
  logic                  q_bit;
  logic [DIVISOR_W-1:0]  step_rem;
  logic [DIVIDEND_W-1:0] step_dvd;

  // One restoring step; the dividend register collects quotient bits from the LSB.
  always_comb begin
    partial  = {rem_q, dvd_q[DIVIDEND_W-1]};
    diff     = partial - {1'b0, dvs_q};
    q_bit    = (partial >= {1'b0, dvs_q});
    step_rem = q_bit ? DIVISOR_W'(diff) : DIVISOR_W'(partial);
    step_dvd = DIVIDEND_W'({dvd_q, q_bit});
  end

  always_comb begin
    state_d   = state_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    quo_d     = quo_q;
    rem_out_d = rem_out_q;
    dbz_d     = dbz_q;

    unique case (state_q)
      IDLE: begin
        if (iStart) begin
          if (iDivisor != '0) begin
            dvd_d   = iDividend;
            dvs_d   = iDivisor;
            rem_d   = '0;
            cnt_d   = CNT_W'(DIVIDEND_W);
            dbz_d   = 1'b0;
            busy_d  = 1'b1;
            state_d = RUN;
          end else begin
            quo_d     = '1;
            rem_out_d = DIVISOR_W'(iDividend);
            dbz_d     = 1'b1;
            done_d    = 1'b1;
            state_d   = DONE;
          end
        end
      end
      RUN: begin
        dvd_d = step_dvd;
        rem_d = step_rem;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          quo_d     = step_dvd;
          rem_out_d = step_rem;
          done_d    = 1'b1;
          state_d   = DONE;
        end else begin
          busy_d = 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= IDLE;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      quo_q     <= '0;
      rem_out_q <= '0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      quo_q     <= quo_d;
      rem_out_q <= rem_out_d;
      dbz_q     <= dbz_d;
    end
  end

  assign oBusy      = busy_q;
  assign oDone      = done_q;
  assign oQuotient  = quo_q;
  assign oRemainder = rem_out_q;
  assign oDivByZero = dbz_q;

endmodule

// File: tb/tb_mini_div.sv
// Bench for mini_div: cycle-level behavioural model using / and %, compared
// every cycle, plus directed scenarios with hand-computed results.
module tb_mini_div;

  localparam int unsigned DW = 8;
  localparam int unsigned VW = 4;

  logic          Clock = 1'b0;
  logic          Reset = 1'b1;
  logic          iStart = 1'b0;
  logic [DW-1:0] iDividend = '0;
  logic [VW-1:0] iDivisor = '0;
  logic          oBusy, oDone, oDivByZero;
  logic [DW-1:0] oQuotient;
  logic [VW-1:0] oRemainder;

  int n_assert = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  mini_div #(.DIVIDEND_W(DW), .DIVISOR_W(VW)) dut (
    .Clock(Clock), .Reset(Reset), .iStart(iStart),
    .iDividend(iDividend), .iDivisor(iDivisor),
    .oBusy(oBusy), .oDone(oDone), .oQuotient(oQuotient),
    .oRemainder(oRemainder), .oDivByZero(oDivByZero)
  );

  always #5 Clock = ~Clock;

  // Model: an operation is "cycles left until result"; result is plain / and %.
  int            m_left = 0;
  bit            m_busy = 0, m_done = 0, m_dbz = 0;
  logic [DW-1:0] m_q = '0, p_q = '0;
  logic [VW-1:0] m_r = '0, p_r = '0;

  always @(posedge Clock) begin
    if (Reset) begin
      m_left = 0; m_busy = 0; m_done = 0; m_dbz = 0; m_q = '0; m_r = '0;
    end else if (m_left > 0) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_busy = 0; m_done = 1; m_q = p_q; m_r = p_r;
      end
    end else if (m_done) begin
      m_done = 0;
    end else if (iStart) begin
      if (iDivisor != 0) begin
        p_q = DW'(iDividend / iDivisor);
        p_r = VW'(iDividend % iDivisor);
        m_dbz = 0; m_left = DW; m_busy = 1;
      end else begin
        m_q = '1; m_r = iDividend[VW-1:0]; m_dbz = 1; m_done = 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge Clock) begin
    if (chk_en) begin
      chk("model_busy", 32'(oBusy), 32'(m_busy));
      chk("model_done", 32'(oDone), 32'(m_done));
      chk("model_quo",  32'(oQuotient), 32'(m_q));
      chk("model_rem",  32'(oRemainder), 32'(m_r));
      chk("model_dbz",  32'(oDivByZero), 32'(m_dbz));
    end
  end

  task automatic start(input logic [DW-1:0] a, input logic [VW-1:0] b);
    @(negedge Clock);
    iStart = 1'b1; iDividend = a; iDivisor = b;
    @(negedge Clock);
    iStart = 1'b0; iDividend = $urandom; iDivisor = $urandom;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!oDone && n < 40) begin
      @(negedge Clock);
      n++;
    end
    if (!oDone) chk({name, "_timeout"}, 32'(oDone), 32'd1);
  endtask

  int busy_cnt;

  initial begin
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    chk_en = 1'b1;
    chk("reset_busy", 32'(oBusy), 32'd0);
    chk("reset_done", 32'(oDone), 32'd0);
    chk("reset_quo",  32'(oQuotient), 32'd0);
    chk("reset_rem",  32'(oRemainder), 32'd0);
    chk("reset_dbz",  32'(oDivByZero), 32'd0);

    // 200/7: busy for exactly 8 cycles, then one-cycle done
    start(8'd200, 4'd7);
    busy_cnt = 0;
    while (oBusy && busy_cnt < 40) begin
      busy_cnt++;
      @(negedge Clock);
    end
    chk("d200_busy_cycles", 32'(busy_cnt), 32'd8);
    chk("d200_done", 32'(oDone), 32'd1);
    chk("d200_q", 32'(oQuotient), 32'd28);
    chk("d200_r", 32'(oRemainder), 32'd4);
    chk("d200_dbz", 32'(oDivByZero), 32'd0);
    @(negedge Clock);
    chk("d200_done_pulse", 32'(oDone), 32'd0);

    // back-to-back
    start(8'd255, 4'd15);
    wait_done("b2b1");
    chk("b2b1_q", 32'(oQuotient), 32'd17);
    chk("b2b1_r", 32'(oRemainder), 32'd0);
    start(8'd5, 4'd9);
    chk("b2b2_busy", 32'(oBusy), 32'd1);
    wait_done("b2b2");
    chk("b2b2_q", 32'(oQuotient), 32'd0);
    chk("b2b2_r", 32'(oRemainder), 32'd5);
    @(negedge Clock);
    chk("b2b2_done_pulse", 32'(oDone), 32'd0);

    // divide by zero goes straight to DONE
    start(8'd9, 4'd0);
    chk("dbz_done", 32'(oDone), 32'd1);
    chk("dbz_busy", 32'(oBusy), 32'd0);
    chk("dbz_q", 32'(oQuotient), 32'hFF);
    chk("dbz_r", 32'(oRemainder), 32'h9);
    chk("dbz_flag", 32'(oDivByZero), 32'd1);
    @(negedge Clock);
    start(8'd9, 4'd3);
    chk("dbz_clear", 32'(oDivByZero), 32'd0);
    chk("dbz_hold_q", 32'(oQuotient), 32'hFF);
    wait_done("d9_3");
    chk("d9_3_q", 32'(oQuotient), 32'd3);
    chk("d9_3_r", 32'(oRemainder), 32'd0);
    @(negedge Clock);

    // iStart during RUN is ignored
    start(8'd200, 4'd7);
    @(negedge Clock);
    iStart = 1'b1; iDividend = 8'd100; iDivisor = 4'd3;
    @(negedge Clock);
    iStart = 1'b0;
    wait_done("ign");
    chk("ign_q", 32'(oQuotient), 32'd28);
    chk("ign_r", 32'(oRemainder), 32'd4);
    repeat (2) @(negedge Clock);
    chk("ign_idle_busy", 32'(oBusy), 32'd0);
    chk("ign_idle_done", 32'(oDone), 32'd0);

    // reset mid-run aborts
    start(8'd200, 4'd7);
    repeat (3) @(negedge Clock);
    Reset = 1'b1; iStart = 1'b1;
    @(negedge Clock);
    Reset = 1'b0; iStart = 1'b0;
    chk("abort_busy", 32'(oBusy), 32'd0);
    chk("abort_q", 32'(oQuotient), 32'd0);
    chk("abort_r", 32'(oRemainder), 32'd0);
    repeat (12) begin
      @(negedge Clock);
      chk("abort_no_done", 32'(oDone), 32'd0);
    end
    start(8'd0, 4'd1);
    wait_done("z1");
    chk("z1_q", 32'(oQuotient), 32'd0);
    chk("z1_r", 32'(oRemainder), 32'd0);

    // random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      @(negedge Clock);
      iStart    = ($urandom_range(0, 2) == 0);
      iDividend = DW'($urandom);
      iDivisor  = ($urandom_range(0, 9) == 0) ? '0 : VW'($urandom);
      Reset     = ($urandom_range(0, 149) == 0);
    end
    @(negedge Clock);
    Reset = 1'b0; iStart = 1'b0;
    repeat (3) @(negedge Clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
